// File: rtl/irq_pkg.sv
// Shared constants and types for the memory-mapped interrupt controller.
// Register word offsets are relative to the controller's base address.
package irq_pkg;

  localparam int IRQ_NUM_SRC          = 16;
  localparam int IRQ_NUM_REGS         = 5;
  localparam int IRQ_ACTIVE_VALID_BIT = 31;

  localparam logic [2:0] IRQ_PENDING = 3'd0;
  localparam logic [2:0] IRQ_MASK    = 3'd1;
  localparam logic [2:0] IRQ_MODE    = 3'd2;
  localparam logic [2:0] IRQ_FORCE   = 3'd3;
  localparam logic [2:0] IRQ_ACTIVE  = 3'd4;

  typedef logic [IRQ_NUM_SRC-1:0] irq_vec_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one raw request line plus rising-edge detect.
// For two clocks after reset the edge register tracks the synchroniser input.
// This stops a line already high at reset release from looking like an edge.
module irq_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_src,
  output logic o_level,
  output logic o_rise
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic [1:0] r_settle;

  // Synchroniser, edge history and post-reset settle counter run every clock
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_prev   <= 1'b0;
      r_settle <= 2'd0;
    end else begin
      r_meta <= i_src;
      r_sync <= r_meta;
      r_prev <= (r_settle == 2'd2) ? r_sync : r_meta;
      if (r_settle != 2'd2) begin
        r_settle <= r_settle + 2'd1;
      end
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;

endmodule

// File: rtl/irq_controller.sv
// 16-source interrupt controller with edge/level pending latches, a mask,
// and a lowest-index-first ACTIVE encoder, snooping the CPU write port.
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [17:0] BASE_ADDR = 18'h3FF00,
  parameter int          NUM_SRC   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clk_en,
  input  logic [15:0] i_irq_src,
  input  logic [3:0]  i_mem_we,
  input  logic [17:0] i_mem_write_addr,
  input  logic [31:0] i_mem_write_data,
  input  logic [17:0] i_mem_read_addr,
  output logic        o_rd_hit,
  output logic [31:0] o_rd_data,
  output logic [15:0] o_interrupts
);

  if (NUM_SRC != IRQ_NUM_SRC) begin : g_bad_num_src
    $error("irq_controller supports exactly 16 sources");
  end

  irq_vec_t    w_level;
  irq_vec_t    w_rise;
  irq_vec_t    r_pending;
  irq_vec_t    r_mask;
  irq_vec_t    r_mode;
  irq_vec_t    w_lane_mask;
  irq_vec_t    w_wbits;
  irq_vec_t    w_w1c;
  irq_vec_t    w_force;
  irq_vec_t    w_pend_next;
  irq_vec_t    w_mask_next;
  irq_vec_t    w_mode_next;
  irq_vec_t    w_enabled;
  logic [17:0] w_wr_off;
  logic [17:0] w_rd_off;
  logic        w_wr_hit;
  logic        w_rd_in_map;
  logic [4:0]  w_active_idx;
  logic [31:0] w_active;
  logic [31:0] w_rd_val;
  logic        w_unused;

  for (genvar gi = 0; gi < IRQ_NUM_SRC; gi++) begin : g_src
    irq_sync_edge u_sync (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_src   (i_irq_src[gi]),
      .o_level (w_level[gi]),
      .o_rise  (w_rise[gi])
    );
  end

  function automatic logic [4:0] lowestIdx(input irq_vec_t v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = IRQ_NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  assign w_wr_off    = i_mem_write_addr - BASE_ADDR;
  assign w_wr_hit    = i_clk_en && (|i_mem_we) && (w_wr_off < 18'(IRQ_NUM_REGS));
  assign w_lane_mask = {{8{i_mem_we[1]}}, {8{i_mem_we[0]}}};
  assign w_wbits     = i_mem_write_data[15:0] & w_lane_mask;

  assign w_w1c   = (w_wr_hit && w_wr_off[2:0] == IRQ_PENDING) ? w_wbits : '0;
  assign w_force = (w_wr_hit && w_wr_off[2:0] == IRQ_FORCE)   ? w_wbits : '0;

  assign w_mask_next = (w_wr_hit && w_wr_off[2:0] == IRQ_MASK) ?
                       ((r_mask & ~w_lane_mask) | w_wbits) : r_mask;
  assign w_mode_next = (w_wr_hit && w_wr_off[2:0] == IRQ_MODE) ?
                       ((r_mode & ~w_lane_mask) | w_wbits) : r_mode;

  // Edge bits: hardware rise and FORCE both beat a same-cycle W1C; level bits track the line
  assign w_pend_next = (r_mode & ((r_pending & ~w_w1c) | w_rise | w_force)) |
                       (~r_mode & w_level);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending    <= '0;
      r_mask       <= '0;
      r_mode       <= '1;
      o_interrupts <= '0;
    end else begin
      r_pending    <= w_pend_next;
      r_mask       <= w_mask_next;
      r_mode       <= w_mode_next;
      o_interrupts <= w_pend_next & w_mask_next;
    end
  end

  assign w_enabled    = r_pending & r_mask;
  assign w_active_idx = lowestIdx(w_enabled);

  always_comb begin
    w_active                       = '0;
    w_active[4:0]                  = w_active_idx;
    w_active[IRQ_ACTIVE_VALID_BIT] = |w_enabled;
  end

  assign w_rd_off    = i_mem_read_addr - BASE_ADDR;
  assign w_rd_in_map = (w_rd_off < 18'(IRQ_NUM_REGS));

  always_comb begin
    w_rd_val = '0;
    case (w_rd_off[2:0])
      IRQ_PENDING: w_rd_val = {16'd0, r_pending};
      IRQ_MASK:    w_rd_val = {16'd0, r_mask};
      IRQ_MODE:    w_rd_val = {16'd0, r_mode};
      IRQ_ACTIVE:  w_rd_val = w_active;
      default:     w_rd_val = '0;
    endcase
  end

  // Read data only advances with the CPU clock enable
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_hit  <= 1'b0;
      o_rd_data <= '0;
    end else if (i_clk_en) begin
      o_rd_hit  <= w_rd_in_map;
      o_rd_data <= w_rd_in_map ? w_rd_val : 32'd0;
    end
  end

  assign w_unused = ^i_mem_write_data[31:16];

endmodule
